free_list: RTL and testbench

//  Physical-register free list for the 2-wide R10K-style out-of-order core.

---
 rtl/free_list.sv | 93 +++++++++
 tb/tb_free_list.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list for a 2-wide R10K-style core: a circular buffer of free tags
// with a speculative head, a retire tail and an architectural head used for one-cycle flush recovery.
module free_list #(
    parameter int PR_NUM = 64,
    parameter int AR_NUM = 32,
    parameter int TAG_W  = 7,
    parameter int DEPTH  = PR_NUM - AR_NUM,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       id_dispatch_num,
    input  logic [1:0]       rob_retire_num,
    input  logic [TAG_W-1:0] rob_retire_tag_a,
    input  logic [TAG_W-1:0] rob_retire_tag_b,
    input  logic             rob_recover,
    output logic [TAG_W-1:0] fl_pr0,
    output logic [TAG_W-1:0] fl_pr1,
    output logic [1:0]       fl_cap,
    output logic [PTR_W-1:0] fl_count,
    output logic             fl_error
);

    localparam int IDX_W = PTR_W - 1;

    logic [TAG_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] arch_head;
    logic             error_q;

    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] head_idx_p1;
    logic [IDX_W-1:0] tail_idx_p1;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] arch_head_next;
    logic [1:0]       eff_d;
    logic [1:0]       req_r;
    logic [1:0]       eff_r;
    logic [PTR_W:0]   space;
    logic             disp_err;
    logic             ret_err;

    // Space available to retire already accounts for tags dispatch frees in the same edge.
    always_comb begin
        count          = tail - head;
        head_idx_p1    = head[IDX_W-1:0] + IDX_W'(1);
        tail_idx_p1    = tail[IDX_W-1:0] + IDX_W'(1);
        fl_cap         = (count >= PTR_W'(2)) ? 2'd2 : count[1:0];
        disp_err       = !rob_recover && (id_dispatch_num > fl_cap);
        eff_d          = rob_recover ? 2'd0
                       : ((id_dispatch_num > fl_cap) ? fl_cap : id_dispatch_num);
        req_r          = (rob_retire_num == 2'd3) ? 2'd2 : rob_retire_num;
        space          = (PTR_W+1)'(DEPTH) - {1'b0, count} + {{(PTR_W-1){1'b0}}, eff_d};
        eff_r          = ({{(PTR_W-1){1'b0}}, req_r} > space) ? space[1:0] : req_r;
        ret_err        = (rob_retire_num == 2'd3) || ({{(PTR_W-1){1'b0}}, req_r} > space);
        tail_next      = tail + PTR_W'(eff_r);
        arch_head_next = arch_head + PTR_W'(eff_r);
        head_next      = rob_recover ? arch_head_next : (head + PTR_W'(eff_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= TAG_W'(AR_NUM + i);
            end
            head      <= '0;
            arch_head <= '0;
            tail      <= PTR_W'(DEPTH);
            error_q   <= 1'b0;
        end else begin
            if (eff_r != 2'd0) begin
                entries[tail[IDX_W-1:0]] <= rob_retire_tag_a;
            end
            if (eff_r == 2'd2) begin
                entries[tail_idx_p1] <= rob_retire_tag_b;
            end
            head      <= head_next;
            tail      <= tail_next;
            arch_head <= arch_head_next;
            if (disp_err || ret_err) begin
                error_q <= 1'b1;
            end
        end
    end

    assign fl_pr0   = entries[head[IDX_W-1:0]];
    assign fl_pr1   = entries[head_idx_p1];
    assign fl_count = count;
    assign fl_error = error_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: table-driven vectors with a scoreboard of expected
// post-edge outputs, plus drain sequences that walk the tag order across the pointer wrap.
module tb_free_list;

    logic       clock;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_tag_a;
    logic [6:0] rob_retire_tag_b;
    logic       rob_recover;
    logic [6:0] fl_pr0;
    logic [6:0] fl_pr1;
    logic [1:0] fl_cap;
    logic [5:0] fl_count;
    logic       fl_error;

    typedef struct {
        logic       rst;
        logic       rec;
        logic [1:0] disp;
        logic [1:0] ret;
        logic [6:0] tag_a;
        logic [6:0] tag_b;
        logic       chk_pr0;
        logic       chk_pr1;
        logic [6:0] pr0;
        logic [6:0] pr1;
        logic [1:0] cap;
        logic [5:0] cnt;
        logic       err;
    } vec_t;

    vec_t       tbl[$];
    vec_t       exp_q[$];
    logic [6:0] tag_q[$];
    int         checks = 0;
    int         errors = 0;
    int         sec_a_end, sec_t4_end, sec_t4_tail_end, sec_t5_end;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .id_dispatch_num  (id_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_tag_a (rob_retire_tag_a),
        .rob_retire_tag_b (rob_retire_tag_b),
        .rob_recover      (rob_recover),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_cap           (fl_cap),
        .fl_count         (fl_count),
        .fl_error         (fl_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int rst, input int rec, input int disp, input int ret,
                                input int ta, input int tb, input int cp0, input int cp1,
                                input int pr0, input int pr1, input int cap, input int cnt,
                                input int err);
        vec_t v;
        v.rst = 1'(rst);    v.rec = 1'(rec);    v.disp = 2'(disp);  v.ret = 2'(ret);
        v.tag_a = 7'(ta);   v.tag_b = 7'(tb);   v.chk_pr0 = 1'(cp0); v.chk_pr1 = 1'(cp1);
        v.pr0 = 7'(pr0);    v.pr1 = 7'(pr1);    v.cap = 2'(cap);    v.cnt = 6'(cnt);
        v.err = 1'(err);
        return v;
    endfunction

    // Fields after the tags: which tag outputs to check, then pr0, pr1, cap, count, error after the edge.
    task automatic fillTables();
        int cnt;
        tbl.push_back(mk(1,0,0,0, 0,0, 1,1, 32,33,2,32,0));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,1, 32,33,2,32,0));
        for (int k = 1; k <= 16; k++) begin
            cnt = 32 - 2*k;
            tbl.push_back(mk(0,0,2,0, 0,0, (k<16),(k<16), 32+2*k,33+2*k,
                             (cnt>=2)?2:cnt, cnt, 0));
        end
        tbl.push_back(mk(0,0,1,0, 0,0, 0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,2, 5,9, 1,1, 5,9,2,2,1));
        tbl.push_back(mk(0,0,1,0, 0,0, 1,0, 9,0,1,1,1));
        tbl.push_back(mk(0,0,2,0, 0,0, 0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,0,2,2, 11,12, 1,1, 32,33,2,32,0));
        tbl.push_back(mk(0,0,0,1, 99,0, 1,1, 32,33,2,32,1));
        sec_a_end = tbl.size();
        tbl.push_back(mk(1,0,0,0, 0,0, 1,1, 32,33,2,32,0));
        tbl.push_back(mk(0,0,2,1, 1,0, 1,1, 34,35,2,31,0));
        tbl.push_back(mk(0,0,2,1, 2,0, 1,1, 36,37,2,30,0));
        tbl.push_back(mk(0,0,2,1, 3,0, 1,1, 38,39,2,29,0));
        sec_t4_end = tbl.size();
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0));
        sec_t4_tail_end = tbl.size();
        tbl.push_back(mk(1,0,0,0, 0,0, 1,1, 32,33,2,32,0));
        tbl.push_back(mk(0,0,2,0, 0,0, 1,1, 34,35,2,30,0));
        tbl.push_back(mk(0,0,2,0, 0,0, 1,1, 36,37,2,28,0));
        tbl.push_back(mk(0,0,2,0, 0,0, 1,1, 38,39,2,26,0));
        tbl.push_back(mk(0,0,0,2, 4,7, 1,1, 38,39,2,28,0));
        tbl.push_back(mk(0,1,2,1, 10,0, 1,1, 35,36,2,32,0));
        sec_t5_end = tbl.size();
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0,0));
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset            = v.rst;
        rob_recover      = v.rec;
        id_dispatch_num  = v.disp;
        rob_retire_num   = v.ret;
        rob_retire_tag_a = v.tag_a;
        rob_retire_tag_b = v.tag_b;
        exp_q.push_back(v);
        @(negedge clock);
    endtask

    task automatic checkOutput(input int row);
        vec_t v;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty row %0d: got 0 entries expected 1", row);
        end else begin
            v = exp_q.pop_front();
            if (v.chk_pr0) checkValue($sformatf("row%0d_pr0", row), 32'(fl_pr0), 32'(v.pr0));
            if (v.chk_pr1) checkValue($sformatf("row%0d_pr1", row), 32'(fl_pr1), 32'(v.pr1));
            checkValue($sformatf("row%0d_cap", row),   32'(fl_cap),   32'(v.cap));
            checkValue($sformatf("row%0d_count", row), 32'(fl_count), 32'(v.cnt));
            checkValue($sformatf("row%0d_error", row), 32'(fl_error), 32'(v.err));
        end
    endtask

    task automatic runRows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(i);
        end
    endtask

    // Dispatch one tag per cycle, checking the head tag and count before each consuming edge.
    task automatic drainSequence(input int n);
        logic [6:0] exp_tag;
        for (int i = 0; i < n; i++) begin
            if (tag_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_queue_empty step %0d: got 0 tags expected 1", i);
            end else begin
                exp_tag = tag_q.pop_front();
                checkValue($sformatf("drain%0d_pr0", i), 32'(fl_pr0), 32'(exp_tag));
                checkValue($sformatf("drain%0d_count", i), 32'(fl_count), 32'(n - i));
            end
            reset           = 1'b0;
            rob_recover     = 1'b0;
            rob_retire_num  = 2'd0;
            id_dispatch_num = 2'd1;
            @(negedge clock);
        end
        id_dispatch_num = 2'd0;
    endtask

    initial begin
        reset            = 1'b1;
        rob_recover      = 1'b0;
        id_dispatch_num  = 2'd0;
        rob_retire_num   = 2'd0;
        rob_retire_tag_a = 7'd0;
        rob_retire_tag_b = 7'd0;
        fillTables();

        runRows(0, sec_a_end);

        runRows(sec_a_end, sec_t4_end);
        for (int t = 38; t <= 63; t++) tag_q.push_back(7'(t));
        tag_q.push_back(7'd1);
        tag_q.push_back(7'd2);
        tag_q.push_back(7'd3);
        drainSequence(29);
        runRows(sec_t4_end, sec_t4_tail_end);

        runRows(sec_t4_tail_end, sec_t5_end);
        for (int t = 35; t <= 63; t++) tag_q.push_back(7'(t));
        tag_q.push_back(7'd4);
        tag_q.push_back(7'd7);
        tag_q.push_back(7'd10);
        drainSequence(32);
        runRows(sec_t5_end, tbl.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
